// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, radix-2 Booth multiply, non-restoring divide.
// Start taken in IDLE/DONE only (no queuing); busy spans MUL/DIV/FIX, done pulses as result/flags update.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               div_zero,
  output logic               illegal
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH+1:0]   acc_q, acc_d;   // Booth high half, or signed partial remainder
  logic [WIDTH-1:0]   qr_q, qr_d;     // multiplier bits, or dividend shifting out / quotient shifting in
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;       // multiplicand, or divisor magnitude
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               zero_q, zero_d, carry_q, carry_d, dz_q, dz_d, ill_q, ill_d;

  logic               accept;
  logic [WIDTH+1:0]   m_ext, d_ext, sum, rsh;
  logic [WIDTH:0]     add_w;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   lo, a_mag, b_mag, quo, rem, rfix;
  logic [SHW-1:0]     sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    ill_d   = ill_q;
    accept  = start && (state_q == IDLE || state_q == DONE);
    m_ext   = {{2{m_q[WIDTH-1]}}, m_q};
    d_ext   = {2'b00, m_q};
    sum     = acc_q;
    rsh     = '0;
    rfix    = '0;
    quo     = '0;
    rem     = '0;
    add_w   = '0;
    dbl     = '0;
    lo      = '0;
    sh      = b[SHW-1:0];
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;

    case (state_q)
      MUL: begin
        if ({qr_q[0], qm1_q} == 2'b01)      sum = acc_q + m_ext;
        else if ({qr_q[0], qm1_q} == 2'b10) sum = acc_q - m_ext;
        acc_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
        qr_d  = {sum[0], qr_q[WIDTH-1:1]};
        qm1_d = qr_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = {acc_d[WIDTH-1:0], qr_d};
          zero_d  = (res_d == '0);
          carry_d = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
        end
      end
      DIV: begin
        rsh   = {acc_q[WIDTH:0], qr_q[WIDTH-1]};
        acc_d = acc_q[WIDTH+1] ? rsh + d_ext : rsh - d_ext;
        qr_d  = {qr_q[WIDTH-2:0], ~acc_d[WIDTH+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // Corrected remainder lies in [0, divisor), so the low WIDTH bits carry it exactly.
        rfix    = acc_q[WIDTH+1] ? acc_q[WIDTH-1:0] + m_q : acc_q[WIDTH-1:0];
        quo     = bz_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -qr_q : qr_q);
        rem     = sa_q ? -rfix : rfix;
        res_d   = {rem, quo};
        zero_d  = (res_d == '0);
        carry_d = 1'b0;
        dz_d    = bz_q;
        ill_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (accept) begin
      cnt_d = '0;
      qm1_d = 1'b0;
      case (op)
        4'b1000: begin
          state_d = MUL;
          acc_d   = '0;
          qr_d    = a;
          m_d     = b;
        end
        4'b1001: begin
          state_d = DIV;
          acc_d   = '0;
          qr_d    = a_mag;
          m_d     = b_mag;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          bz_d    = (b == '0);
        end
        default: begin
          state_d = DONE;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          ill_d   = 1'b0;
          case (op)
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b0010: begin
              add_w   = {1'b0, a} + {1'b0, b};
              lo      = add_w[WIDTH-1:0];
              carry_d = add_w[WIDTH];
            end
            4'b0011: begin
              lo      = a - b;
              carry_d = (a >= b);
            end
            4'b0100: lo = a >> sh;
            4'b0101: lo = a << sh;
            4'b0110: begin
              dbl = {a, a} >> sh;
              lo  = dbl[WIDTH-1:0];
            end
            4'b0111: begin
              dbl = {a, a} << sh;
              lo  = dbl[2*WIDTH-1:WIDTH];
            end
            4'b1010: lo = -a;
            4'b1011: lo = ~a;
            default: ill_d = 1'b1;
          endcase
          res_d  = {{WIDTH{1'b0}}, lo};
          zero_d = (lo == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign div_zero = dz_q;
  assign illegal  = ill_q;
endmodule
